// File: rtl/ball_pkg.sv
// Shared table geometry, fixed-point widths and FSM state type for the ball
// motion block.
package ball_pkg;

  localparam int TABLE_LEFT   = 32;
  localparam int TABLE_TOP    = 32;
  localparam int TABLE_RIGHT  = 608;
  localparam int TABLE_BOTTOM = 448;
  localparam int BALL_SIZE    = 32;

  localparam int MAX_X = TABLE_RIGHT - BALL_SIZE;
  localparam int MAX_Y = TABLE_BOTTOM - BALL_SIZE;

  // Position is unsigned Q11.6, velocity is signed Q5.6.
  localparam int FRAC_W = 6;
  localparam int INT_W  = 11;
  localparam int POS_W  = INT_W + FRAC_W;
  localparam int VEL_W  = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MOVING   = 2'd1,
    ST_POCKETED = 2'd2
  } ball_state_e;

  // -1024 has no positive counterpart, so it is pulled in to -1023 to keep
  // bounce negation symmetric.
  function automatic logic [VEL_W-1:0] vel_sat(input logic [VEL_W-1:0] v);
    if (v == {1'b1, {(VEL_W-1){1'b0}}})
      return {1'b1, {(VEL_W-2){1'b0}}, 1'b1};
    return v;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One motion axis: integrate velocity, bounce off the [LO, HI] bounds, then
// apply friction. The next-frame result is exposed so the top can test pockets.
module ball_axis
  import ball_pkg::*;
#(
  parameter int INIT     = 160,
  parameter int LO       = 32,
  parameter int HI       = 576,
  parameter int FRICTION = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             respawn,
  input  logic             load_vel,
  input  logic [VEL_W-1:0] load_val,
  input  logic             step,
  input  logic             zero_vel,
  output logic [INT_W-1:0] pos_int,
  output logic [INT_W-1:0] next_pos_int,
  output logic [VEL_W-1:0] next_vel
);

  localparam logic signed [POS_W:0]   LO_FX   = (POS_W+1)'(LO * (1 << FRAC_W));
  localparam logic signed [POS_W:0]   HI_FX   = (POS_W+1)'(HI * (1 << FRAC_W));
  localparam logic [POS_W-1:0]        INIT_FX = POS_W'(INIT * (1 << FRAC_W));
  localparam logic signed [VEL_W-1:0] FR      = VEL_W'(FRICTION);

  logic [POS_W-1:0]        pos;
  logic [POS_W-1:0]        next_pos;
  logic signed [VEL_W-1:0] vel;
  logic signed [POS_W:0]   sum;
  logic signed [VEL_W-1:0] bounced;
  logic signed [VEL_W-1:0] fric;

  // The extra sign bit on sum makes an underflow past 0 read as below LO.
  always_comb begin
    sum      = $signed({1'b0, pos}) + $signed({{(POS_W+1-VEL_W){vel[VEL_W-1]}}, vel});
    next_pos = sum[POS_W-1:0];
    bounced  = vel;
    if (sum < LO_FX) begin
      next_pos = LO_FX[POS_W-1:0];
      bounced  = -vel;
    end else if (sum > HI_FX) begin
      next_pos = HI_FX[POS_W-1:0];
      bounced  = -vel;
    end
    if (bounced > FR)
      fric = bounced - FR;
    else if (bounced < -FR)
      fric = bounced + FR;
    else
      fric = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      pos <= INIT_FX;
      vel <= '0;
    end else if (step) begin
      pos <= next_pos;
      vel <= zero_vel ? '0 : fric;
    end else if (load_vel) begin
      vel <= $signed(load_val);
    end
  end

  assign pos_int      = pos[POS_W-1:FRAC_W];
  assign next_pos_int = next_pos[POS_W-1:FRAC_W];
  assign next_vel     = fric;

endmodule

// File: rtl/ball_move.sv
// Cue-ball motion: IDLE/MOVING/POCKETED FSM driving two ball_axis instances,
// one frame step per startOfFrame pulse.
module ball_move
  import ball_pkg::*;
#(
  parameter int INIT_X      = 160,
  parameter int INIT_Y      = 224,
  parameter int FRICTION    = 2,
  parameter int POCKET_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        hitValid,
  input  logic [10:0] hitVelX,
  input  logic [10:0] hitVelY,
  input  logic        respawn,
  output logic        hitReady,
  output logic [10:0] ballTopLeftPosX,
  output logic [10:0] ballTopLeftPosY,
  output logic        ballShow,
  output logic        ballMoving,
  output logic        pocketed
);

  ball_state_e      state, state_next;
  logic             hit_acc, frame_step, in_pocket, capture;
  logic [VEL_W-1:0] vx_load, vy_load, vx_next, vy_next;
  logic [INT_W-1:0] nx, ny;

  // Strike handshake: a hit transfers on any cycle where hitValid and hitReady
  // are both high; hitReady depends only on state, never on hitValid.
  assign hitReady   = (state == ST_IDLE);
  assign hit_acc    = hitValid && hitReady;
  assign vx_load    = vel_sat(hitVelX);
  assign vy_load    = vel_sat(hitVelY);
  assign frame_step = (state == ST_MOVING) && startOfFrame;

  assign in_pocket = ((nx <= INT_W'(TABLE_LEFT + POCKET_SIZE)) || (nx >= INT_W'(MAX_X - POCKET_SIZE))) &&
                     ((ny <= INT_W'(TABLE_TOP + POCKET_SIZE))  || (ny >= INT_W'(MAX_Y - POCKET_SIZE)));
  assign capture   = frame_step && in_pocket;

  ball_axis #(.INIT(INIT_X), .LO(TABLE_LEFT), .HI(MAX_X), .FRICTION(FRICTION)) u_x (
    .clk(clk), .reset(reset), .respawn(respawn), .load_vel(hit_acc), .load_val(vx_load),
    .step(frame_step), .zero_vel(in_pocket), .pos_int(ballTopLeftPosX),
    .next_pos_int(nx), .next_vel(vx_next)
  );

  ball_axis #(.INIT(INIT_Y), .LO(TABLE_TOP), .HI(MAX_Y), .FRICTION(FRICTION)) u_y (
    .clk(clk), .reset(reset), .respawn(respawn), .load_vel(hit_acc), .load_val(vy_load),
    .step(frame_step), .zero_vel(in_pocket), .pos_int(ballTopLeftPosY),
    .next_pos_int(ny), .next_vel(vy_next)
  );

  always_comb begin
    state_next = state;
    if (respawn) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (hit_acc && ((vx_load != '0) || (vy_load != '0)))
            state_next = ST_MOVING;
        ST_MOVING:
          if (capture)
            state_next = ST_POCKETED;
          else if (frame_step && (vx_next == '0) && (vy_next == '0))
            state_next = ST_IDLE;
        ST_POCKETED: state_next = ST_POCKETED;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pocketed <= 1'b0;
    end else begin
      state    <= state_next;
      pocketed <= capture && !respawn;
    end
  end

  assign ballShow   = (state != ST_POCKETED);
  assign ballMoving = (state == ST_MOVING);

endmodule

// File: tb/tb_ball_move.sv
// Bench for ball_move: a behavioural model predicts every cycle of the default
// instance, plus two re-parameterised instances for wall-bounce and pocket cases.
module tb_ball_move;

  localparam int W    = 26;
  localparam int FRIC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sof = 1'b0;
  logic        respawn = 1'b0;
  logic        hv0 = 1'b0, hv1 = 1'b0, hv2 = 1'b0;
  logic [10:0] hvx = '0, hvy = '0;

  logic        rdy0, show0, mov0, pk0;
  logic [10:0] x0, y0;
  logic        rdy1, show1, mov1, pk1;
  logic [10:0] x1, y1;
  logic        rdy2, show2, mov2, pk2;
  logic [10:0] x2, y2;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  int m_px, m_py, m_vx, m_vy, m_st;
  bit m_pk;

  ball_move dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hitValid(hv0), .hitVelX(hvx), .hitVelY(hvy),
    .respawn(respawn), .hitReady(rdy0), .ballTopLeftPosX(x0), .ballTopLeftPosY(y0),
    .ballShow(show0), .ballMoving(mov0), .pocketed(pk0)
  );

  ball_move #(.INIT_X(575), .INIT_Y(224)) dut_e (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hitValid(hv1), .hitVelX(hvx), .hitVelY(hvy),
    .respawn(respawn), .hitReady(rdy1), .ballTopLeftPosX(x1), .ballTopLeftPosY(y1),
    .ballShow(show1), .ballMoving(mov1), .pocketed(pk1)
  );

  ball_move #(.INIT_X(50), .INIT_Y(50)) dut_p (
    .clk(clk), .reset(reset), .startOfFrame(sof), .hitValid(hv2), .hitVelX(hvx), .hitVelY(hvy),
    .respawn(respawn), .hitReady(rdy2), .ballTopLeftPosX(x2), .ballTopLeftPosY(y2),
    .ballShow(show2), .ballMoving(mov2), .pocketed(pk2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_px = 160 * 64; m_py = 224 * 64; m_vx = 0; m_vy = 0; m_st = 0; m_pk = 0;
  endtask

  task automatic axis_step(input int lo, input int hi, inout int p, inout int v);
    int s;
    s = p + v;
    if (s < lo * 64) begin
      p = lo * 64; v = -v;
    end else if (s > hi * 64) begin
      p = hi * 64; v = -v;
    end else begin
      p = s;
    end
    if (v > FRIC) v = v - FRIC;
    else if (v < -FRIC) v = v + FRIC;
    else v = 0;
  endtask

  task automatic model_cycle(input bit h, input int vx, input int vy, input bit s, input bit r);
    int nx, ny;
    m_pk = 0;
    if (r) begin
      model_reset();
    end else if (m_st == 0) begin
      if (h) begin
        m_vx = (vx == -1024) ? -1023 : vx;
        m_vy = (vy == -1024) ? -1023 : vy;
        if (m_vx != 0 || m_vy != 0) m_st = 1;
      end
    end else if (m_st == 1 && s) begin
      axis_step(32, 576, m_px, m_vx);
      axis_step(32, 416, m_py, m_vy);
      nx = m_px / 64;
      ny = m_py / 64;
      if ((nx <= 48 || nx >= 560) && (ny <= 48 || ny >= 400)) begin
        m_st = 2; m_vx = 0; m_vy = 0; m_pk = 1;
      end else if (m_vx == 0 && m_vy == 0) begin
        m_st = 0;
      end
    end
  endtask

  // One clock of stimulus on the default instance, scoreboarded against the model.
  task automatic cycle(input bit h, input int vx, input int vy, input bit s, input bit r);
    logic [W-1:0] got, exp_v;
    hv0 = h; hvx = 11'(vx); hvy = 11'(vy); sof = s; respawn = r;
    model_cycle(h, vx, vy, s, r);
    exp_q.push_back({11'(m_px / 64), 11'(m_py / 64), m_st != 2, m_st == 1, m_pk, m_st == 0});
    @(posedge clk); #1;
    hv0 = 1'b0; sof = 1'b0; respawn = 1'b0;
    got   = {x0, y0, show0, mov0, pk0, rdy0};
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL sb_cycle got x=%0d y=%0d show/mov/pk/rdy=%b required x=%0d y=%0d show/mov/pk/rdy=%b",
               got[25:15], got[14:4], got[3:0], exp_v[25:15], exp_v[14:4], exp_v[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if ({x0, y0} !== {11'd160, 11'd224}) begin
      errors++; $display("FAIL reset_pos got %0d,%0d required 160,224", x0, y0);
    end
    checks++;
    if ({show0, mov0, rdy0, pk0} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags got show/mov/rdy/pk=%b required 1010", {show0, mov0, rdy0, pk0});
    end
  endtask

  task automatic test_hit_integrate();
    cycle(1, 128, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (x0 !== 11'd162 || dut.u_x.vel !== 11'd126) begin
      errors++; $display("FAIL integ_f1 got x=%0d vx=%0d required x=162 vx=126", x0, $signed(dut.u_x.vel));
    end
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (x0 !== 11'd163 || dut.u_x.pos[5:0] !== 6'd62 || dut.u_x.vel !== 11'd124) begin
      errors++; $display("FAIL integ_f2 got x=%0d frac=%0d vx=%0d required x=163 frac=62 vx=124",
                         x0, dut.u_x.pos[5:0], $signed(dut.u_x.vel));
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_friction();
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (dut.u_x.vel !== 11'd1 || mov0 !== 1'b1) begin
      errors++; $display("FAIL fric_f1 got vx=%0d mov=%b required vx=1 mov=1", $signed(dut.u_x.vel), mov0);
    end
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (dut.u_x.vel !== 11'd0 || mov0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++; $display("FAIL fric_stop got vx=%0d mov=%b rdy=%b required vx=0 mov=0 rdy=1",
                         $signed(dut.u_x.vel), mov0, rdy0);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_zero_hit();
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (rdy0 !== 1'b1 || mov0 !== 1'b0) begin
      errors++; $display("FAIL zero_hit got rdy=%b mov=%b required rdy=1 mov=0", rdy0, mov0);
    end
  endtask

  task automatic test_hit_with_frame();
    cycle(1, 64, 0, 1, 0);
    checks++;
    if (x0 !== 11'd160 || dut.u_x.vel !== 11'd64 || mov0 !== 1'b1) begin
      errors++; $display("FAIL hit_sof got x=%0d vx=%0d mov=%b required x=160 vx=64 mov=1",
                         x0, $signed(dut.u_x.vel), mov0);
    end
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (x0 !== 11'd161) begin
      errors++; $display("FAIL hit_sof_move got x=%0d required 161", x0);
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_bounce();
    hvx = 11'd128; hvy = 11'd0; hv1 = 1'b1;
    tick();
    hv1 = 1'b0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (x1 !== 11'd576 || dut_e.u_x.vel !== 11'(-126) || y1 !== 11'd224) begin
      errors++; $display("FAIL bounce_clamp got x=%0d y=%0d vx=%0d required x=576 y=224 vx=-126",
                         x1, y1, $signed(dut_e.u_x.vel));
    end
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (x1 !== 11'd574) begin
      errors++; $display("FAIL bounce_back got x=%0d required 574", x1);
    end
  endtask

  task automatic test_pocket();
    hvx = 11'(-256); hvy = 11'(-256); hv2 = 1'b1;
    tick();
    hv2 = 1'b0;
    cycle(0, 0, 0, 1, 0);
    checks++;
    if ({x2, y2} !== {11'd46, 11'd46} || {pk2, show2, mov2, rdy2} !== 4'b1000) begin
      errors++; $display("FAIL pocket_enter got %0d,%0d pk/show/mov/rdy=%b required 46,46 1000",
                         x2, y2, {pk2, show2, mov2, rdy2});
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (pk2 !== 1'b0 || show2 !== 1'b0) begin
      errors++; $display("FAIL pocket_pulse got pk=%b show=%b required pk=0 show=0", pk2, show2);
    end
    hvx = 11'd300; hvy = 11'd300; hv2 = 1'b1;
    tick();
    hv2 = 1'b0;
    cycle(0, 0, 0, 1, 0);
    checks++;
    if ({x2, y2} !== {11'd46, 11'd46} || {pk2, show2, mov2, rdy2} !== 4'b0000 || dut_p.u_x.vel !== 11'd0) begin
      errors++; $display("FAIL pocket_hold got %0d,%0d pk/show/mov/rdy=%b vx=%0d required 46,46 0000 vx=0",
                         x2, y2, {pk2, show2, mov2, rdy2}, $signed(dut_p.u_x.vel));
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({x2, y2} !== {11'd50, 11'd50} || show2 !== 1'b1 || rdy2 !== 1'b1) begin
      errors++; $display("FAIL pocket_respawn got %0d,%0d show=%b rdy=%b required 50,50 show=1 rdy=1",
                         x2, y2, show2, rdy2);
    end
  endtask

  task automatic test_respawn_priority();
    cycle(1, 200, 100, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 300, 300, 1, 1);
    checks++;
    if ({x0, y0} !== {11'd160, 11'd224} || mov0 !== 1'b0 || rdy0 !== 1'b1 ||
        dut.u_x.vel !== 11'd0 || dut.u_y.vel !== 11'd0) begin
      errors++; $display("FAIL respawn_prio got %0d,%0d mov=%b rdy=%b vx=%0d vy=%0d required 160,224 0 1 0 0",
                         x0, y0, mov0, rdy0, $signed(dut.u_x.vel), $signed(dut.u_y.vel));
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 200, -150, 0, 0);
    cycle(0, 0, 0, 1, 0);
    reset = 1'b1; sof = 1'b1; hv0 = 1'b1; hvx = 11'd100;
    tick();
    reset = 1'b0; sof = 1'b0; hv0 = 1'b0;
    model_reset();
    checks++;
    if ({x0, y0} !== {11'd160, 11'd224} || show0 !== 1'b1 || mov0 !== 1'b0 || dut.u_x.vel !== 11'd0) begin
      errors++; $display("FAIL reset_mid got %0d,%0d show=%b mov=%b vx=%0d required 160,224 1 0 0",
                         x0, y0, show0, mov0, $signed(dut.u_x.vel));
    end
  endtask

  task automatic test_random();
    int vx, vy;
    for (int it = 0; it < 30; it++) begin
      cycle(0, 0, 0, 0, 1);
      vx = int'($urandom_range(0, 2046)) - 1023;
      vy = int'($urandom_range(0, 2046)) - 1023;
      cycle(1, vx, vy, 0, 0);
      for (int f = 0; f < 60 && m_st == 1; f++) begin
        cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 2046)) - 1023,
              int'($urandom_range(0, 2046)) - 1023, 1'b1, 1'b0);
        if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_integrate();
    test_friction();
    test_zero_hit();
    test_hit_with_frame();
    test_bounce();
    test_pocket();
    test_respawn_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
